// File: rtl/secuenciador_rampa.sv
// Soft-start sequencer for the motor power stage: ramps 30% -> 50% -> 100% on
// start and 100% -> 50% -> 30% -> off on stop, with a fixed dwell per step.
//
//   state  | meaning
//   IDLE   | motor off, waiting for a start request
//   S30    | ramp-up, 30% level, timed
//   S50    | ramp-up, 50% level, timed
//   S100   | full speed, holds until stop or fault
//   BAJA50 | ramp-down, 50% level, timed
//   BAJA30 | ramp-down, 30% level, timed
//   FALLA  | fault shutdown, exits when falla and arranque are both low
module secuenciador_rampa #(
  parameter int DWELL_LENTO  = 8,
  parameter int DWELL_RAPIDO = 2,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       arranque,
  input  logic       Rapido,
  input  logic       Lento,
  input  logic       paro,
  input  logic       falla,
  output logic       out_30,
  output logic       out_50,
  output logic       out_100,
  output logic       en_rampa,
  output logic       listo,
  output logic [2:0] estado
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S30    = 3'd1,
    S50    = 3'd2,
    S100   = 3'd3,
    BAJA50 = 3'd4,
    BAJA30 = 3'd5,
    FALLA  = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] CARGA_LENTO  = CNT_W'(DWELL_LENTO - 1);
  localparam logic [CNT_W-1:0] CARGA_RAPIDO = CNT_W'(DWELL_RAPIDO - 1);
  localparam logic [CNT_W-1:0] UNO          = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rapido_q, rapido_d;
  logic             out_30_q, out_30_d;
  logic             out_50_q, out_50_d;
  logic             out_100_q, out_100_d;
  logic             en_rampa_q, en_rampa_d;
  logic             listo_q, listo_d;

  logic             modo_rapido;
  logic [CNT_W-1:0] carga;
  logic [CNT_W-1:0] cnt_dec;
  logic             cnt_fin;

  // Mode chosen at start; with neither select asserted the safe slow ramp is used.
  always_comb begin
    modo_rapido = 1'b0;
    case ({Rapido, Lento})
      2'b10, 2'b11: modo_rapido = 1'b1;
      2'b01:        modo_rapido = 1'b0;
      default:      modo_rapido = 1'b0;
    endcase
  end

  assign carga   = rapido_q ? CARGA_RAPIDO : CARGA_LENTO;
  assign cnt_fin = (cnt_q == '0);
  assign cnt_dec = cnt_fin ? cnt_q : (cnt_q - UNO);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rapido_d = rapido_q;

    if (falla) begin
      state_d = FALLA;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arranque && !paro) begin
            state_d  = S30;
            rapido_d = modo_rapido;
            cnt_d    = modo_rapido ? CARGA_RAPIDO : CARGA_LENTO;
          end
        end
        S30: begin
          if (paro) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_fin) begin
            state_d = S50;
            cnt_d   = carga;
          end else begin
            cnt_d = cnt_dec;
          end
        end
        S50: begin
          if (paro) begin
            state_d = BAJA30;
            cnt_d   = carga;
          end else if (cnt_fin) begin
            state_d = S100;
            cnt_d   = carga;
          end else begin
            cnt_d = cnt_dec;
          end
        end
        S100: begin
          if (paro) begin
            state_d = BAJA50;
            cnt_d   = carga;
          end
        end
        BAJA50: begin
          if (cnt_fin) begin
            state_d = BAJA30;
            cnt_d   = carga;
          end else begin
            cnt_d = cnt_dec;
          end
        end
        BAJA30: begin
          if (cnt_fin) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_dec;
          end
        end
        FALLA: begin
          if (!arranque) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they register in step with estado.
  always_comb begin
    out_30_d   = (state_d == S30) || (state_d == BAJA30);
    out_50_d   = (state_d == S50) || (state_d == BAJA50);
    out_100_d  = (state_d == S100);
    en_rampa_d = (state_d == S30) || (state_d == S50) ||
                 (state_d == BAJA50) || (state_d == BAJA30);
    listo_d    = (state_d == S100);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rapido_q   <= 1'b0;
      out_30_q   <= 1'b0;
      out_50_q   <= 1'b0;
      out_100_q  <= 1'b0;
      en_rampa_q <= 1'b0;
      listo_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rapido_q   <= rapido_d;
      out_30_q   <= out_30_d;
      out_50_q   <= out_50_d;
      out_100_q  <= out_100_d;
      en_rampa_q <= en_rampa_d;
      listo_q    <= listo_d;
    end
  end

  assign out_30   = out_30_q;
  assign out_50   = out_50_q;
  assign out_100  = out_100_q;
  assign en_rampa = en_rampa_q;
  assign listo    = listo_q;
  assign estado   = state_q;

endmodule
